regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's general-purpose register file.
- Provides the architectural GPRs with two combinational read ports and a debug/display read port.
- Adds dedicated HI/LO registers that do not alias GPRs 30/31, asynchronous clear, optional write-to-read bypass, and a per-register busy scoreboard used by decode for hazard stalls.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries, and entry 0 is hardwired to zero.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return stored contents only.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wen  in  1  GPR write enable.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- test_addr  in  ADDR_W  debug/display read address.
- test_data  out  DATA_W  debug/display read data (combinational, never bypassed).
- hi_lo_wen  in  1  HI/LO write enable.
- hi_wdata  in  DATA_W  HI write data.
- lo_wdata  in  DATA_W  LO write data.
- hi_rdata  out  DATA_W  HI contents.
- lo_rdata  out  DATA_W  LO contents.
- issue_valid  in  1  an instruction writing GPR issue_addr has issued.
- issue_addr  in  ADDR_W  destination GPR of the issuing instruction.
- hilo_issue  in  1  an instruction writing HI/LO has issued.
- busy1  out  1  raddr1 has a pending write.
- busy2  out  1  raddr2 has a pending write.
- hilo_busy  out  1  HI/LO has a pending write.

Behaviour:
- Reset (resetn=0, asynchronous, effective mid-cycle):
  - All GPRs, HI, LO, every busy bit and hilo_busy clear to 0.
  - All read outputs therefore read 0.
  - Writes and issues presented while in reset are ignored.
  - Release is synchronous to clk; the first update occurs on the first rising edge with resetn=1.
- GPR write: on posedge, if wen && waddr!=0, rf[waddr] <= wdata. Writes to address 0 are discarded.
- HI/LO write: on posedge, if hi_lo_wen, HI <= hi_wdata and LO <= lo_wdata. GPR and HI/LO writes in the same cycle are independent.
- Reads:
  - rdataN = 0 when raddrN==0.
  - Otherwise, with BYPASS=1, wen && waddr==raddrN gives rdataN = wdata.
  - Otherwise rdataN = rf[raddrN].
  - With BYPASS=1, hi_rdata/lo_rdata likewise return hi_wdata/lo_wdata while hi_lo_wen=1.
  - test_data = rf[test_addr] (0 at address 0), with no bypass.
- Scoreboard, one busy bit per GPR, bit 0 constantly 0:
  - Set on posedge when issue_valid && issue_addr!=0.
  - Cleared on posedge when wen && waddr matches.
  - Same address set and cleared in the same cycle: set wins (the newer producer is outstanding).
  - Different addresses: both actions apply.
  - Issuing to an already-busy register keeps it busy (single outstanding producer per register; the pipeline guarantees in-order writeback).
  - busyN = sb[raddrN], unmodified by a same-cycle clear. The bypass already supplies the data, so decode must treat (busyN && !(BYPASS && wen && waddr==raddrN)) as the stall condition.
- hilo_busy:
  - Set on hilo_issue, cleared on hi_lo_wen.
  - Simultaneous set and clear: set wins.
- Latency:
  - Writes are visible through the stored-read path on the cycle after the edge.
  - With BYPASS=1, writes are also visible on the same cycle.
- Widths: no arithmetic; every data path is exactly DATA_W bits and every address ADDR_W bits, with no truncation or extension.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse resetn low between edges -> rdata1 (raddr1=5), hi_rdata, lo_rdata and busy1 read 0 immediately, without waiting for a clock edge.
- Zero register: wen=1, waddr=0, wdata=0xFFFFFFFF, raddr1=0 -> rdata1=0 in that cycle and after; test_data at address 0 = 0.
- Bypass: r7=0x11111111; wen=1, waddr=7, wdata=0x22222222, raddr2=7.
  - BYPASS=1 -> rdata2=0x22222222 in the same cycle, while test_data (test_addr=7) still shows 0x11111111.
  - BYPASS=0 -> rdata2=0x11111111, then 0x22222222 on the next cycle.
- HI/LO independence: hi_lo_wen=1 with hi_wdata=0xA, lo_wdata=0xB, plus wen=1 to r30 with wdata=0xC -> next cycle hi_rdata=0xA, lo_rdata=0xB, r30=0xC, r31 unchanged.
- Scoreboard race: issue_valid, issue_addr=9 -> busy1 (raddr1=9) is 1 on the next cycle.
  - Later, issue_addr=9 and wen/waddr=9 in the same cycle -> busy stays 1.
  - Then wen/waddr=9 alone -> busy1 is 0 on the following cycle.
- hilo_busy: hilo_issue at cycle n -> hilo_busy=1 at n+1; hi_lo_wen at n+3 -> hilo_busy=0 at n+4.

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- general-purpose register file with HI/LO and busy scoreboard
//
// Holds 2**ADDR_W GPRs (entry 0 reads as zero) with two combinational read
// ports and a never-bypassed debug port.  It adds dedicated HI/LO registers,
// an optional same-cycle write-to-read bypass, and one busy bit per GPR plus
// one for HI/LO.  Decode uses the busy bits for hazard stalls.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   wen, waddr, wdata           GPR write from writeback
//   raddr1/rdata1, raddr2/rdata2  combinational read ports
//   test_addr/test_data         debug/display read, stored contents only
//   hi_lo_wen, hi_wdata, lo_wdata  HI/LO write
//   hi_rdata, lo_rdata          HI/LO contents (bypassed when BYPASS=1)
//   issue_valid, issue_addr     GPR producer issued (marks destination busy)
//   hilo_issue                  HI/LO producer issued
//   busy1, busy2, hilo_busy     pending-write flags
//
// Handshake: issue_valid, hilo_issue, wen and hi_lo_wen are single-cycle
// qualifiers with no ready.  Each one is consumed on the rising edge where
// it is high.  Decode must only raise an issue when it is not stalling, and
// writeback presents each result exactly once.
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] test_addr,
   output logic [DATA_W-1:0] test_data,
   input  logic              hi_lo_wen,
   input  logic [DATA_W-1:0] hi_wdata,
   input  logic [DATA_W-1:0] lo_wdata,
   output logic [DATA_W-1:0] hi_rdata,
   output logic [DATA_W-1:0] lo_rdata,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              hilo_issue,
   output logic              busy1,
   output logic              busy2,
   output logic              hilo_busy
);

   localparam int   NREG    = 1 << ADDR_W;
   localparam logic BYP_CFG = (BYPASS != 0);

   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [NREG-1:0]   sb_q;
   logic [NREG-1:0]   sb_next;
   logic              hilo_busy_q;
   logic              byp_en;

   // Writes are ignored while reset is held.  The bypass is also gated, so
   // every read output is zero throughout reset.
   assign byp_en = BYP_CFG && resetn;

   // Storage: entry 0 is cleared on reset and never written.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wen && (waddr != '0)) rf[waddr] <= wdata;
         if (hi_lo_wen) begin
            hi_q <= hi_wdata;
            lo_q <= lo_wdata;
         end
      end
   end

   // The clear is applied before the set, so a new producer issued to the
   // register being written back stays outstanding.
   always_comb begin
      sb_next = sb_q;
      if (wen) sb_next[waddr] = 1'b0;
      if (issue_valid) sb_next[issue_addr] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_q        <= '0;
         hilo_busy_q <= 1'b0;
      end else begin
         sb_q <= sb_next;
         if (hilo_issue)     hilo_busy_q <= 1'b1;
         else if (hi_lo_wen) hilo_busy_q <= 1'b0;
      end
   end

   // Read ports
   always_comb begin
      rdata1 = rf[raddr1];
      if (raddr1 == '0)                            rdata1 = '0;
      else if (byp_en && wen && (waddr == raddr1)) rdata1 = wdata;

      rdata2 = rf[raddr2];
      if (raddr2 == '0)                            rdata2 = '0;
      else if (byp_en && wen && (waddr == raddr2)) rdata2 = wdata;

      test_data = (test_addr == '0) ? '0 : rf[test_addr];

      hi_rdata = (byp_en && hi_lo_wen) ? hi_wdata : hi_q;
      lo_rdata = (byp_en && hi_lo_wen) ? lo_wdata : lo_q;
   end

   // Busy reflects registered state only.  When writeback hits the same
   // register this cycle, the bypass already supplies the data, and decode
   // masks the stall itself.
   assign busy1     = sb_q[raddr1];
   assign busy2     = sb_q[raddr2];
   assign hilo_busy = hilo_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb
// Two instances share all inputs: u_dut (BYPASS=1) and u_nb (BYPASS=0).
// Expected values are queued as stimulus is applied and popped at each check.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int W  = 32;
   localparam int AW = 5;

   logic          clk;
   logic          resetn;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [W-1:0]  wdata;
   logic [AW-1:0] raddr1;
   logic [AW-1:0] raddr2;
   logic [AW-1:0] test_addr;
   logic          hi_lo_wen;
   logic [W-1:0]  hi_wdata;
   logic [W-1:0]  lo_wdata;
   logic          issue_valid;
   logic [AW-1:0] issue_addr;
   logic          hilo_issue;

   logic [W-1:0]  rdata1, rdata2, test_data, hi_rdata, lo_rdata;
   logic          busy1, busy2, hilo_busy;
   logic [W-1:0]  nb_rdata1, nb_rdata2, nb_test_data, nb_hi_rdata, nb_lo_rdata;
   logic          nb_busy1, nb_busy2, nb_hilo_busy;

   logic [W-1:0]  exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   regfile_sb #(.DATA_W(W), .ADDR_W(AW), .BYPASS(1)) u_dut (
      .clk(clk), .resetn(resetn),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rdata1),
      .raddr2(raddr2), .rdata2(rdata2),
      .test_addr(test_addr), .test_data(test_data),
      .hi_lo_wen(hi_lo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .hilo_issue(hilo_issue),
      .busy1(busy1), .busy2(busy2), .hilo_busy(hilo_busy)
   );

   regfile_sb #(.DATA_W(W), .ADDR_W(AW), .BYPASS(0)) u_nb (
      .clk(clk), .resetn(resetn),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(nb_rdata1),
      .raddr2(raddr2), .rdata2(nb_rdata2),
      .test_addr(test_addr), .test_data(nb_test_data),
      .hi_lo_wen(hi_lo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .hi_rdata(nb_hi_rdata), .lo_rdata(nb_lo_rdata),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .hilo_issue(hilo_issue),
      .busy1(nb_busy1), .busy2(nb_busy2), .hilo_busy(nb_hilo_busy)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen         = 1'b0;
      hi_lo_wen   = 1'b0;
      issue_valid = 1'b0;
      hilo_issue  = 1'b0;
   endtask

   // Scoreboard
   task automatic expect_val(input logic [W-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] exp;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: observed %h, required a queued expectation", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
         end
      end
   endtask

   logic [W-1:0]  rnd_data;
   logic [AW-1:0] rnd_addr;

   initial begin
      resetn = 1'b0; idle();
      waddr = '0; wdata = '0; raddr1 = 5; raddr2 = '0; test_addr = 5;
      hi_wdata = '0; lo_wdata = '0; issue_addr = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      expect_val(0); expect_val(0); expect_val(0); expect_val(0); expect_val(0);
      #1;
      check("rst_rdata1", rdata1);
      check("rst_test_data", test_data);
      check("rst_hi", hi_rdata);
      check("rst_busy1", 32'(busy1));
      check("rst_hilo_busy", 32'(hilo_busy));
      resetn = 1'b1;

      // Write r5, HI/LO, and issue r5 in the same cycle (the set wins)
      tick();
      wen = 1; waddr = 5; wdata = 32'hDEADBEEF;
      hi_lo_wen = 1; hi_wdata = 32'h1234; lo_wdata = 32'h5678;
      issue_valid = 1; issue_addr = 5; raddr1 = 5;
      expect_val(32'hDEADBEEF); expect_val(0); expect_val(32'h1234); expect_val(0);
      #1;
      check("byp_r5_same_cycle", rdata1);
      check("nb_r5_same_cycle", nb_rdata1);
      check("byp_hi_same_cycle", hi_rdata);
      check("nb_hi_same_cycle", nb_hi_rdata);
      tick(); idle();
      expect_val(32'hDEADBEEF); expect_val(32'hDEADBEEF); expect_val(32'h1234);
      expect_val(32'h5678); expect_val(1);
      #1;
      check("r5_stored", rdata1);
      check("r5_test_data", test_data);
      check("hi_stored", hi_rdata);
      check("lo_stored", lo_rdata);
      check("busy_set_wins", 32'(busy1));

      // Asynchronous reset between edges
      #2; resetn = 1'b0;
      expect_val(0); expect_val(0); expect_val(0); expect_val(0);
      #1;
      check("async_rst_rdata1", rdata1);
      check("async_rst_hi", hi_rdata);
      check("async_rst_lo", lo_rdata);
      check("async_rst_busy1", 32'(busy1));
      // Writes and issues presented during reset are ignored
      tick();
      wen = 1; waddr = 5; wdata = 32'hCAFEF00D; issue_valid = 1; issue_addr = 5;
      expect_val(0);
      #1;
      check("rst_no_bypass", rdata1);
      tick(); idle(); resetn = 1'b1;
      tick();
      expect_val(0); expect_val(0);
      #1;
      check("rst_write_ignored", rdata1);
      check("rst_issue_ignored", 32'(busy1));

      // Zero register
      tick();
      wen = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; test_addr = 0;
      issue_valid = 1; issue_addr = 0;
      expect_val(0); expect_val(0);
      #1;
      check("r0_same_cycle", rdata1);
      check("r0_test_data_same", test_data);
      tick(); idle();
      expect_val(0); expect_val(0); expect_val(0);
      #1;
      check("r0_after", rdata1);
      check("r0_test_data_after", test_data);
      check("r0_never_busy", 32'(busy1));

      // Bypass versus stored read
      wen = 1; waddr = 7; wdata = 32'h11111111;
      tick();
      wen = 1; waddr = 7; wdata = 32'h22222222; raddr2 = 7; test_addr = 7;
      expect_val(32'h22222222); expect_val(32'h11111111); expect_val(32'h11111111);
      #1;
      check("byp_rdata2", rdata2);
      check("byp_test_data_old", test_data);
      check("nb_rdata2_old", nb_rdata2);
      tick(); idle();
      expect_val(32'h22222222); expect_val(32'h22222222);
      #1;
      check("nb_rdata2_new", nb_rdata2);
      check("byp_rdata2_new", rdata2);

      // HI/LO are independent of r30/r31
      wen = 1; waddr = 31; wdata = 32'h31313131;
      tick();
      hi_lo_wen = 1; hi_wdata = 32'hA; lo_wdata = 32'hB;
      wen = 1; waddr = 30; wdata = 32'hC;
      tick(); idle(); raddr1 = 30; raddr2 = 31;
      expect_val(32'hA); expect_val(32'hB); expect_val(32'hC);
      expect_val(32'h31313131); expect_val(32'hA);
      #1;
      check("hilo_hi", hi_rdata);
      check("hilo_lo", lo_rdata);
      check("hilo_r30", rdata1);
      check("hilo_r31", rdata2);
      check("nb_hilo_hi", nb_hi_rdata);

      // Random write/read-back sweep through the stored path
      for (int i = 0; i < 8; i++) begin
         rnd_addr = AW'($urandom_range(1, 29));
         rnd_data = $urandom;
         wen = 1; waddr = rnd_addr; wdata = rnd_data;
         tick(); idle(); test_addr = rnd_addr; raddr1 = rnd_addr;
         expect_val(rnd_data); expect_val(rnd_data);
         #1;
         check("rand_test_data", test_data);
         check("rand_nb_rdata1", nb_rdata1);
      end

      // Scoreboard: set, same-cycle race, clear
      issue_valid = 1; issue_addr = 9; raddr1 = 9;
      expect_val(0);
      #1;
      check("sb_not_yet", 32'(busy1));
      tick(); idle();
      expect_val(1);
      #1;
      check("sb_set", 32'(busy1));
      repeat ($urandom_range(1, 3)) tick();
      issue_valid = 1; issue_addr = 9; wen = 1; waddr = 9; wdata = 32'h99;
      expect_val(1);
      #1;
      check("sb_race_same_cycle", 32'(busy1));
      tick(); idle();
      expect_val(1);
      #1;
      check("sb_race_set_wins", 32'(busy1));
      wen = 1; waddr = 9; wdata = 32'h999;
      expect_val(1);
      #1;
      check("sb_clear_unmodified", 32'(busy1));
      tick(); idle();
      expect_val(0);
      #1;
      check("sb_cleared", 32'(busy1));

      // Different addresses set and clear together; a re-issue keeps busy
      issue_valid = 1; issue_addr = 10;
      tick(); idle();
      issue_valid = 1; issue_addr = 11; wen = 1; waddr = 10; wdata = 32'h10;
      raddr1 = 10; raddr2 = 11;
      tick(); idle();
      expect_val(0); expect_val(1);
      #1;
      check("sb_diff_clear", 32'(busy1));
      check("sb_diff_set", 32'(busy2));
      issue_valid = 1; issue_addr = 11;
      tick(); idle();
      expect_val(1);
      #1;
      check("sb_reissue", 32'(busy2));

      // hilo_busy timing
      hilo_issue = 1;                       // cycle n
      tick(); idle();
      expect_val(1);
      #1;
      check("hilo_busy_n1", 32'(hilo_busy));
      tick();
      expect_val(1);
      #1;
      check("hilo_busy_n2", 32'(hilo_busy));
      tick();
      hi_lo_wen = 1; hi_wdata = 32'h5; lo_wdata = 32'h6;   // cycle n+3
      expect_val(1);
      #1;
      check("hilo_busy_n3", 32'(hilo_busy));
      tick(); idle();
      expect_val(0);
      #1;
      check("hilo_busy_n4", 32'(hilo_busy));
      hilo_issue = 1; hi_lo_wen = 1;
      tick(); idle();
      expect_val(1);
      #1;
      check("hilo_set_wins", 32'(hilo_busy));

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL queue_drain: observed %0d left, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
